// File: rtl/phase_select_mux_if.sv
// Handshake-free control/data bundle between the CDR loop logic and the phase selector.
// Carries the oversampled phase vector, step/load commands and the selector's outputs.
// master drives phases and commands; slave (the selector) drives selection and status.
interface phase_select_mux_if #(
  parameter int N_PHASES = 8,
  parameter int SEL_W    = $clog2(N_PHASES)
);
  // Inputs to the selector
  logic [N_PHASES-1:0] phases;
  logic                step_up;
  logic                step_dn;
  logic                load;
  logic [SEL_W-1:0]    load_sel;

  // Outputs from the selector
  logic                data_out;
  logic [SEL_W-1:0]    sel;
  logic                step_ack;
  logic                slip_up;
  logic                slip_dn;
  logic                busy;

  modport master (
    output phases, step_up, step_dn, load, load_sel,
    input  data_out, sel, step_ack, slip_up, slip_dn, busy
  );

  modport slave (
    input  phases, step_up, step_dn, load, load_sel,
    output data_out, sel, step_ack, slip_up, slip_dn, busy
  );
endinterface

// File: rtl/phase_select_mux.sv
// Registered N:1 phase selector steered by single-step up/down commands with hold-off.
// Latency: command -> sel/status at the same edge; sel -> data_out one edge later.
// No backpressure: steps arriving while busy or together with load are dropped, never queued.
module phase_select_mux #(
  parameter int N_PHASES = 8,
  parameter int SEL_W    = $clog2(N_PHASES),
  parameter int HOLDOFF  = 4,
  parameter int INIT_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  phase_select_mux_if.slave    bus
);

  // Hold-off counter must hold HOLDOFF; a zero hold-off still gets a 1-bit counter.
  localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int SEL_WP = SEL_W + 1;

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_PHASES - 1);
  localparam logic [SEL_W-1:0]  SEL_INIT  = SEL_W'(INIT_SEL);
  localparam logic [SEL_WP-1:0] SEL_LIMIT = SEL_WP'(N_PHASES);
  localparam logic [HO_W-1:0]   HO_LOAD   = HO_W'(HOLDOFF);

  // Registered state
  logic [SEL_W-1:0] r_sel;
  logic [HO_W-1:0]  r_cnt;
  logic             r_data;
  logic             r_ack;
  logic             r_slip_up;
  logic             r_slip_dn;

  // Decode of the current cycle's request
  logic             w_busy;
  logic             w_one_step;
  logic             w_accept;
  logic             w_load_ok;
  logic             w_at_last;
  logic             w_at_first;
  logic [SEL_W-1:0] w_sel_inc;
  logic [SEL_W-1:0] w_sel_dec;
  logic [SEL_W-1:0] w_sel_step;
  logic [HO_W-1:0]  w_cnt_next;

  assign w_busy     = (r_cnt != '0);
  // Opposing requests in the same cycle cancel each other.
  assign w_one_step = bus.step_up ^ bus.step_dn;
  assign w_accept   = !bus.load && w_one_step && !w_busy;

  // Out-of-range load values (possible when N_PHASES is not a power of two) are ignored.
  assign w_load_ok  = ({1'b0, bus.load_sel} < SEL_LIMIT);

  // Modulo-N_PHASES stepping; the wrap points also drive the slip flags.
  assign w_at_last  = (r_sel == SEL_LAST);
  assign w_at_first = (r_sel == '0);
  assign w_sel_inc  = w_at_last  ? '0       : r_sel + SEL_W'(1);
  assign w_sel_dec  = w_at_first ? SEL_LAST : r_sel - SEL_W'(1);
  assign w_sel_step = bus.step_up ? w_sel_inc : w_sel_dec;

  // Counter free-runs down to zero unless reloaded by an accepted step or cleared by load.
  assign w_cnt_next = w_busy ? (r_cnt - HO_W'(1)) : r_cnt;

  // Selection, hold-off counter and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= SEL_INIT;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_slip_up <= 1'b0;
      r_slip_dn <= 1'b0;
    end else begin
      r_ack     <= 1'b0;
      r_slip_up <= 1'b0;
      r_slip_dn <= 1'b0;
      r_cnt     <= w_cnt_next;
      if (bus.load) begin
        if (w_load_ok) begin
          r_sel <= bus.load_sel;
        end
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sel     <= w_sel_step;
        r_ack     <= 1'b1;
        r_cnt     <= HO_LOAD;
        r_slip_up <= bus.step_up && w_at_last;
        r_slip_dn <= bus.step_dn && w_at_first;
      end
    end
  end

  // Data register samples the phase chosen by the selection held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= 1'b0;
    end else begin
      r_data <= bus.phases[r_sel];
    end
  end

  assign bus.data_out = r_data;
  assign bus.sel      = r_sel;
  assign bus.step_ack = r_ack;
  assign bus.slip_up  = r_slip_up;
  assign bus.slip_dn  = r_slip_dn;
  assign bus.busy     = w_busy;

  // A single step can only wrap in one direction.
  a_slip_excl: assert property (@(posedge clk) disable iff (rst) !(r_slip_up && r_slip_dn));

  // Selection never leaves the legal phase range.
  a_sel_range: assert property (@(posedge clk) disable iff (rst) ({1'b0, r_sel} < SEL_LIMIT));

endmodule
